ex_alu_stage: RTL and testbench

//  Execute-stage ALU with a registered, back-pressurable output (2-entry skid buffer).

---
 rtl/ex_alu_stage.sv | 152 +++++++++++++++
 tb/tb_ex_alu_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU feeding a 2-entry skid buffer (main + skid registers).
// The main register drives the outputs; InReady is decoded from registered state only.
module ex_alu_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic [RD_WIDTH-1:0]   RdIn,
   input  logic                  Flush,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  BranchTaken,
   output logic [RD_WIDTH-1:0]   RdOut
);

   localparam int SHW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_res_q, main_res_d;
   logic                  main_bt_q, main_bt_d;
   logic [RD_WIDTH-1:0]   main_rd_q, main_rd_d;
   logic [DATA_WIDTH-1:0] skid_res_q, skid_res_d;
   logic                  skid_bt_q, skid_bt_d;
   logic [RD_WIDTH-1:0]   skid_rd_q, skid_rd_d;

   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_bt;
   logic [SHW-1:0]        shamt;
   logic                  lt_s;
   logic                  accept;
   logic                  pop;

   assign shamt = SrcB[SHW-1:0];
   assign lt_s  = $signed(SrcA) < $signed(SrcB);

   always_comb begin
      alu_res = '0;
      alu_bt  = 1'b0;
      case (Operation)
         4'b0000: alu_res = SrcA & SrcB;
         4'b0001: alu_res = SrcA | SrcB;
         4'b0010: alu_res = SrcA + SrcB;
         4'b0011: alu_res = SrcA << shamt;
         4'b0100: alu_res = SrcA >> shamt;
         4'b0101: alu_res = SrcA - SrcB;
         4'b0110: alu_res = $unsigned($signed(SrcA) >>> shamt);
         4'b0111,
         4'b1110: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         4'b1000: alu_bt  = (SrcA == SrcB);
         4'b1001: alu_bt  = (SrcA != SrcB);
         4'b1010: alu_bt  = lt_s;
         4'b1011: alu_bt  = !lt_s;
         4'b1100: alu_res = SrcA ^ SrcB;
         4'b1101: alu_res = SrcB;
         default: alu_res = '0;
      endcase
      // Branch ops mirror their condition into bit 0 of the result.
      if (Operation[3:2] == 2'b10) begin
         alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_bt};
      end
   end

   assign InReady     = (state_q != TWO);
   assign OutValid    = (state_q != EMPTY);
   assign ALUResult   = main_res_q;
   assign BranchTaken = main_bt_q;
   assign RdOut       = main_rd_q;

   assign accept = InValid && InReady;
   assign pop    = OutValid && OutReady;

   always_comb begin
      state_d    = state_q;
      main_res_d = main_res_q;
      main_bt_d  = main_bt_q;
      main_rd_d  = main_rd_q;
      skid_res_d = skid_res_q;
      skid_bt_d  = skid_bt_q;
      skid_rd_d  = skid_rd_q;
      if (Flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d    = ONE;
                  main_res_d = alu_res;
                  main_bt_d  = alu_bt;
                  main_rd_d  = RdIn;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_res_d = alu_res;
                  main_bt_d  = alu_bt;
                  main_rd_d  = RdIn;
               end else if (accept) begin
                  state_d    = TWO;
                  skid_res_d = alu_res;
                  skid_bt_d  = alu_bt;
                  skid_rd_d  = RdIn;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d    = ONE;
                  main_res_d = skid_res_q;
                  main_bt_d  = skid_bt_q;
                  main_rd_d  = skid_rd_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= EMPTY;
         main_res_q <= '0;
         main_bt_q  <= 1'b0;
         main_rd_q  <= '0;
         skid_res_q <= '0;
         skid_bt_q  <= 1'b0;
         skid_rd_q  <= '0;
      end else begin
         state_q    <= state_d;
         main_res_q <= main_res_d;
         main_bt_q  <= main_bt_d;
         main_rd_q  <= main_rd_d;
         skid_res_q <= skid_res_d;
         skid_bt_q  <= skid_bt_d;
         skid_rd_q  <= skid_rd_d;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, branches, backpressure, flush and async reset.
module tb_ex_alu_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        InValid;
   logic        InReady;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [4:0]  RdIn;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] ALUResult;
   logic        BranchTaken;
   logic [4:0]  RdOut;

   int checks = 0;
   int errors = 0;

   ex_alu_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
      .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
      .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .RdIn(RdIn),
      .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
      .ALUResult(ALUResult), .BranchTaken(BranchTaken), .RdOut(RdOut)
   );

   always #5 clk = ~clk;

   // Drive one op with OutReady=1 and sample the registered result after the edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      InValid = 1'b1; OutReady = 1'b1; Operation = op; SrcA = a; SrcB = b; RdIn = rd;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         InValid = 1'b0; Flush = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
      Operation = 4'd0; SrcA = '0; SrcB = '0; RdIn = '0;
      #12;
      checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1 || ALUResult !== 32'd0 ||
          BranchTaken !== 1'b0 || RdOut !== 5'd0) begin
         errors++;
         $display("FAIL reset_state: ov=%b ir=%b res=%h bt=%b rd=%0d expected 0 1 0 0 0",
                  OutValid, InReady, ALUResult, BranchTaken, RdOut);
      end
      @(negedge clk); reset_n = 1'b1;
      issue(4'b0101, 32'd5, 32'd7, 5'd3);
      checks++;
      if (OutValid !== 1'b1 || ALUResult !== 32'hFFFFFFFE || RdOut !== 5'd3) begin
         errors++;
         $display("FAIL first_sub: ov=%b res=%h rd=%0d expected 1 fffffffe 3",
                  OutValid, ALUResult, RdOut);
      end
      idle(2);
   endtask

   task automatic test_alu_ops;
      logic [3:0]  ops  [9] = '{4'b0110, 4'b0100, 4'b0011, 4'b0111, 4'b1110,
                                4'b1101, 4'b1100, 4'b0000, 4'b0001};
      logic [31:0] as   [9] = '{32'h80000000, 32'h80000000, 32'd1, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0000F000};
      logic [31:0] bs   [9] = '{32'd36, 32'd36, 32'd36, 32'd1, 32'd1,
                                32'h12345000, 32'hFFFF0000, 32'h0FF00FF0, 32'h0000000F};
      logic [31:0] exps [9] = '{32'hF8000000, 32'h08000000, 32'h00000010, 32'd1, 32'd1,
                                32'h12345000, 32'h0F0FF0F0, 32'h0F000F00, 32'h0000F00F};
      for (int i = 0; i < 9; i++) begin
         issue(ops[i], as[i], bs[i], 5'(i + 1));
         checks++;
         if (OutValid !== 1'b1 || ALUResult !== exps[i] || BranchTaken !== 1'b0 ||
             RdOut !== 5'(i + 1)) begin
            errors++;
            $display("FAIL alu_op%0d op=%b: ov=%b res=%h bt=%b rd=%0d expected 1 %h 0 %0d",
                     i, ops[i], OutValid, ALUResult, BranchTaken, RdOut, exps[i], i + 1);
         end
      end
      idle(2);
   endtask

   task automatic test_branches;
      logic [3:0]  ops [6] = '{4'b1011, 4'b1001, 4'b1010, 4'b0010, 4'b1000, 4'b1111};
      logic [31:0] as  [6] = '{32'hFFFFFFFD, 32'd9, 32'hFFFFFFFE, 32'd4, 32'd9, 32'd5};
      logic [31:0] bs  [6] = '{32'hFFFFFFFD, 32'd9, 32'd1, 32'd5, 32'd9, 32'd6};
      logic [31:0] er  [6] = '{32'd1, 32'd0, 32'd1, 32'd9, 32'd1, 32'd0};
      logic        eb  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], as[i], bs[i], 5'd7);
         checks++;
         if (ALUResult !== er[i] || BranchTaken !== eb[i]) begin
            errors++;
            $display("FAIL branch%0d op=%b: res=%h bt=%b expected %h %b",
                     i, ops[i], ALUResult, BranchTaken, er[i], eb[i]);
         end
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      OutReady = 1'b0; InValid = 1'b1; Operation = 4'b0010; SrcA = 32'd0; SrcB = 32'd1; RdIn = 5'd1;
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || ALUResult !== 32'd1 || InReady !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: ov=%b res=%h ir=%b expected 1 1 1", OutValid, ALUResult, InReady);
      end
      @(negedge clk); SrcB = 32'd2; RdIn = 5'd2;
      @(posedge clk); #1;
      checks++;
      if (InReady !== 1'b0 || ALUResult !== 32'd1 || RdOut !== 5'd1) begin
         errors++;
         $display("FAIL bp_full: ir=%b res=%h rd=%0d expected 0 1 1", InReady, ALUResult, RdOut);
      end
      @(negedge clk); SrcB = 32'd3; RdIn = 5'd3;
      @(posedge clk); #1;
      checks++;
      if (InReady !== 1'b0 || OutValid !== 1'b1 || ALUResult !== 32'd1) begin
         errors++;
         $display("FAIL bp_hold: ir=%b ov=%b res=%h expected 0 1 1", InReady, OutValid, ALUResult);
      end
      @(negedge clk); OutReady = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ALUResult !== 32'd2 || RdOut !== 5'd2 || InReady !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: res=%h rd=%0d ir=%b expected 2 2 1", ALUResult, RdOut, InReady);
      end
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || ALUResult !== 32'd3 || RdOut !== 5'd3) begin
         errors++;
         $display("FAIL bp_third: ov=%b res=%h rd=%0d expected 1 3 3", OutValid, ALUResult, RdOut);
      end
      @(negedge clk); InValid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: ov=%b expected 0", OutValid);
      end
   endtask

   task automatic test_flush;
      @(negedge clk);
      OutReady = 1'b0; InValid = 1'b1; Operation = 4'b0010; SrcA = 32'd10; SrcB = 32'd0; RdIn = 5'd4;
      @(negedge clk); SrcA = 32'd20;
      @(negedge clk); SrcA = 32'd30; Flush = 1'b1;
      checks++;
      if (InReady !== 1'b0) begin
         errors++;
         $display("FAIL flush_setup: ir=%b expected 0", InReady);
      end
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b0 || InReady !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty: ov=%b ir=%b expected 0 1", OutValid, InReady);
      end
      @(negedge clk); Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_item%0d: ov=%b expected 0", i, OutValid);
         end
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      OutReady = 1'b0; InValid = 1'b1; Operation = 4'b0010; SrcA = 32'd7; SrcB = 32'd0; RdIn = 5'd9;
      @(negedge clk); SrcA = 32'd8;
      @(posedge clk); #2;
      InValid = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (OutValid !== 1'b0 || ALUResult !== 32'd0 || InReady !== 1'b1 || RdOut !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: ov=%b res=%h ir=%b rd=%0d expected 0 0 1 0",
                  OutValid, ALUResult, InReady, RdOut);
      end
      @(negedge clk); reset_n = 1'b1;
      issue(4'b0010, 32'd2, 32'd2, 5'd6);
      checks++;
      if (OutValid !== 1'b1 || ALUResult !== 32'd4 || RdOut !== 5'd6) begin
         errors++;
         $display("FAIL post_reset_add: ov=%b res=%h rd=%0d expected 1 4 6", OutValid, ALUResult, RdOut);
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_branches();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
